nios2_c_cpu_oci_dct_ctrl: RTL and testbench

Debug-trace capture sequencer for the OCI. It packs 2-bit trace atoms from the CPU into a 30-bit frame (dct_buffer) with a fill count (dct_count), then hands each frame downstream over a valid/ready handshake. It flushes partial frames on idle timeout, on trace disable, or when test_ending is seen, and then raises test_has_ended. It feeds the OCI test bench and trace FIFO.

---
 rtl/nios2_c_cpu_oci_dct_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_nios2_c_cpu_oci_dct_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_c_cpu_oci_dct_ctrl.sv
// -----------------------------------------------------------------------------
// nios2_c_cpu_oci_dct_ctrl
//
// Debug-trace capture sequencer for the OCI. It packs 2-bit trace atoms into a
// 30-bit frame (dct_buffer) with a fill count (dct_count) and offers each frame
// downstream over a valid/ready handshake. A partial frame is flushed on idle
// timeout, on trace disable, or when test_ending is seen. After the last frame
// is handed over, test_has_ended is raised and capture stops until reset.
//
// Handshakes (both directions use the same rule):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The receiver may change ready freely. Once frame_valid is raised it stays
//   high, with dct_buffer/dct_count stable, until the cycle frame_ready=1.
//   An atom is taken on any edge where atom_valid & atom_ready.
//
// Parameters:
//   ATOMS_PER_FRAME  atoms per full frame (1..15)
//   FLUSH_TIMEOUT    idle cycles with a non-empty partial frame before a
//                    forced flush (2..255)
//
// Optional build macro:
//   DCT_LOSSY_MODE_EN  atom_ready stays high while a frame is waiting to be
//                      taken; atoms arriving then are dropped and counted on
//                      the extra drop_count port (saturating at 0xFFFF).
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   trace_en       capture enable
//   atom_valid     atom presented
//   atom[1:0]      trace atom
//   atom_ready     atom accepted this cycle when atom_valid=1
//   test_ending    level request for a final flush and stop
//   frame_valid    dct_buffer/dct_count hold a frame for downstream
//   frame_ready    downstream accepts the frame
//   dct_buffer     packed atoms, atom k in bits [2k+1:2k]
//   dct_count      number of valid atoms in dct_buffer
//   test_has_ended capture finished, sticky until reset
//   drop_count     (lossy build only) atoms dropped while a frame was pending
//   dbg_state      current sequencer state (0=PACK, 1=FLUSH, 2=DONE)
// -----------------------------------------------------------------------------
module nios2_c_cpu_oci_dct_ctrl #(
  parameter int ATOMS_PER_FRAME = 15,
  parameter int FLUSH_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_en,
  input  logic        atom_valid,
  input  logic [1:0]  atom,
  output logic        atom_ready,
  input  logic        test_ending,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_has_ended,
`ifdef DCT_LOSSY_MODE_EN
  output logic [15:0] drop_count,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    PACK  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] FRAME_ATOMS = 4'(ATOMS_PER_FRAME);
  localparam logic [7:0] TMO_MAX     = 8'(FLUSH_TIMEOUT);
  localparam logic [7:0] TMO_LAST    = 8'(FLUSH_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [29:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  idle_q, idle_d;
  logic        final_q, final_d;

  logic        accept;
  logic [3:0]  cnt_inc;
  logic        non_empty_after;
  logic        timeout_hit;

  // ---------------------------------------------------------------------------
  // Handshake-facing outputs
  // ---------------------------------------------------------------------------
  assign test_has_ended = (state_q == DONE);
  assign frame_valid    = (state_q == FLUSH);
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign dbg_state      = state_q;

`ifdef DCT_LOSSY_MODE_EN
  // Ready is kept high during FLUSH as well; those atoms are discarded below.
  assign atom_ready = trace_en & ~test_has_ended;
`else
  assign atom_ready = trace_en & (state_q == PACK);
`endif

  // Only PACK actually stores an atom, whatever atom_ready says.
  assign accept          = atom_valid & atom_ready & (state_q == PACK);
  assign cnt_inc         = cnt_q + 4'd1;
  assign non_empty_after = accept | (cnt_q != 4'd0);

  // The cycle in which the idle counter would reach FLUSH_TIMEOUT is the
  // timeout cycle; an atom accepted in that same cycle still joins the frame.
  assign timeout_hit = (cnt_q != 4'd0) && (idle_q >= TMO_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    final_d = final_q;

    unique case (state_q)
      PACK: begin
        if (accept) begin
          buf_d[{cnt_q, 1'b0} +: 2] = atom;
          cnt_d                     = cnt_inc;
          idle_d                    = 8'd0;
        end else if ((cnt_q != 4'd0) && (idle_q < TMO_MAX)) begin
          idle_d = idle_q + 8'd1;
        end

        if (test_ending) begin
          if (non_empty_after) begin
            state_d = FLUSH;
            final_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else if (accept && (cnt_inc == FRAME_ATOMS)) begin
          state_d = FLUSH;
        end else if (!trace_en && (cnt_q != 4'd0)) begin
          state_d = FLUSH;
        end else if (timeout_hit) begin
          state_d = FLUSH;
        end

        if (state_d != PACK) begin
          idle_d = 8'd0;
        end
      end

      FLUSH: begin
        if (frame_ready) begin
          buf_d   = 30'd0;
          cnt_d   = 4'd0;
          state_d = (final_q || test_ending) ? DONE : PACK;
        end else if (test_ending) begin
          // Remember the stop request; the pending handshake still completes.
          final_d = 1'b1;
        end
      end

      DONE: begin
        // Terminal until reset.
      end

      default: begin
        state_d = PACK;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PACK;
      buf_q   <= 30'd0;
      cnt_q   <= 4'd0;
      idle_q  <= 8'd0;
      final_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      final_q <= final_d;
    end
  end

`ifdef DCT_LOSSY_MODE_EN
  // ---------------------------------------------------------------------------
  // Dropped-atom counter (saturating)
  // ---------------------------------------------------------------------------
  logic drop_event;
  assign drop_event = (state_q == FLUSH) & atom_valid & atom_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= 16'd0;
    end else if (drop_event && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nios2_c_cpu_oci_dct_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for nios2_c_cpu_oci_dct_ctrl.
// A frame-level model (queue of atoms, pending-frame flag, ended flag) predicts
// every output; a compare process checks it on each falling edge. Directed
// sequences add hand-computed literal expectations, then a randomized phase
// with occasional resets and test_ending pulses exercises the rest.
// -----------------------------------------------------------------------------
module tb_nios2_c_cpu_oci_dct_ctrl;

  localparam int APF = 15;
  localparam int TMO = 64;
`ifdef DCT_LOSSY_MODE_EN
  localparam bit LOSSY = 1'b1;
`else
  localparam bit LOSSY = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trace_en = 1'b0;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom = 2'd0;
  logic        test_ending = 1'b0;
  logic        frame_ready = 1'b0;
  logic        atom_ready;
  logic        frame_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;
  logic [1:0]  dbg_state;
`ifdef DCT_LOSSY_MODE_EN
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  nios2_c_cpu_oci_dct_ctrl #(
    .ATOMS_PER_FRAME(APF),
    .FLUSH_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trace_en(trace_en),
    .atom_valid(atom_valid),
    .atom(atom),
    .atom_ready(atom_ready),
    .test_ending(test_ending),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .dct_buffer(dct_buffer),
    .dct_count(dct_count),
    .test_has_ended(test_has_ended),
`ifdef DCT_LOSSY_MODE_EN
    .drop_count(drop_count),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: atoms collected so far, the frame offered downstream,
  // and whether capture has finished.
  // ---------------------------------------------------------------------------
  logic [1:0]  m_q[$];
  bit          m_out = 0;
  bit          m_final = 0;
  bit          m_ended = 0;
  int          m_idle = 0;
  logic [29:0] m_frame = '0;
  int          m_fcnt = 0;
  int          m_drops = 0;

  function automatic logic [29:0] pack_q();
    logic [29:0] b;
    b = '0;
    foreach (m_q[i]) b[2*i +: 2] = m_q[i];
    return b;
  endfunction

  task automatic present(input bit fin);
    m_frame = pack_q();
    m_fcnt  = m_q.size();
    m_q.delete();
    m_out   = 1;
    m_idle  = 0;
    if (fin) m_final = 1;
  endtask

  task automatic model_step();
    bit acc;
    bit tmo;
    if (reset) begin
      m_q.delete();
      m_out = 0; m_final = 0; m_ended = 0; m_idle = 0;
      m_frame = '0; m_fcnt = 0; m_drops = 0;
    end else if (m_ended) begin
      // capture finished; nothing changes until reset
    end else if (m_out) begin
      if (LOSSY && atom_valid && trace_en && m_drops < 65535) m_drops++;
      if (frame_ready) begin
        m_out = 0; m_frame = '0; m_fcnt = 0;
        if (m_final || test_ending) m_ended = 1;
      end else if (test_ending) begin
        m_final = 1;
      end
    end else begin
      acc = trace_en && atom_valid;
      tmo = (m_q.size() > 0) && (m_idle >= TMO - 1);
      if (acc) begin
        m_q.push_back(atom);
        m_idle = 0;
      end else if (m_q.size() > 0) begin
        m_idle++;
      end
      if (test_ending) begin
        if (m_q.size() > 0) present(1'b1);
        else m_ended = 1;
      end else if (m_q.size() == APF) begin
        present(1'b0);
      end else if (!trace_en && m_q.size() > 0) begin
        present(1'b0);
      end else if (tmo) begin
        present(1'b0);
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // Compare process: every falling edge, all outputs against the model.
  initial forever begin
    @(negedge clk);
    chk("frame_valid", 32'(frame_valid), 32'(m_out));
    chk("dct_count", 32'(dct_count), m_out ? m_fcnt : m_q.size());
    chk("dct_buffer", 32'(dct_buffer), 32'(m_out ? m_frame : pack_q()));
    chk("atom_ready", 32'(atom_ready),
        32'(trace_en && !m_ended && (LOSSY || !m_out)));
    chk("test_has_ended", 32'(test_has_ended), 32'(m_ended));
`ifdef DCT_LOSSY_MODE_EN
    chk("drop_count", 32'(drop_count), m_drops);
`endif
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    trace_en = 0; atom_valid = 0; test_ending = 0; frame_ready = 0;
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    cyc();
  endtask

  task automatic push_atom(input logic [1:0] v);
    atom_valid = 1;
    atom = v;
    cyc();
    atom_valid = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [29:0] exp_buf;
  int          vprob;

  initial begin
    // Reset state
    #1;
    chk("rst_frame_valid", 32'(frame_valid), 0);
    chk("rst_atom_ready", 32'(atom_ready), 0);
    chk("rst_count", 32'(dct_count), 0);
    chk("rst_buffer", 32'(dct_buffer), 0);
    chk("rst_ended", 32'(test_has_ended), 0);
    do_reset();

    // Full frame, values k%4, back to back, downstream ready
    trace_en = 1; frame_ready = 1;
    for (int k = 0; k < APF; k++) begin
      atom_valid = 1; atom = 2'(k % 4);
      cyc();
    end
    atom_valid = 0;
    chk("full_fv", 32'(frame_valid), 1);
    chk("full_buf", 32'(dct_buffer), 32'h24E4E4E4);
    chk("full_cnt", 32'(dct_count), 15);
    cyc();
    chk("full_clr_fv", 32'(frame_valid), 0);
    chk("full_clr_cnt", 32'(dct_count), 0);
    chk("full_clr_buf", 32'(dct_buffer), 0);

    // Backpressure: frame held stable for 10 cycles
    do_reset();
    trace_en = 1; frame_ready = 0;
    exp_buf = '0;
    for (int k = 0; k < APF; k++) begin
      atom = 2'($urandom_range(0, 3));
      exp_buf[2*k +: 2] = atom;
      atom_valid = 1;
      cyc();
    end
    for (int c = 0; c < 10; c++) begin
      atom_valid = 1;
      #1;
      chk("bp_fv", 32'(frame_valid), 1);
      chk("bp_buf", 32'(dct_buffer), 32'(exp_buf));
      chk("bp_cnt", 32'(dct_count), 15);
      chk("bp_ready", 32'(atom_ready), 32'(LOSSY));
      cyc();
    end
    atom_valid = 0; frame_ready = 1;
    cyc();
    chk("bp_done_fv", 32'(frame_valid), 0);
    chk("bp_done_cnt", 32'(dct_count), 0);

    // Idle timeout with 3 atoms of value 3
    do_reset();
    trace_en = 1; frame_ready = 0;
    for (int k = 0; k < 3; k++) push_atom(2'd3);
    for (int c = 0; c < TMO - 1; c++) cyc();
    chk("tmo_early_fv", 32'(frame_valid), 0);
    cyc();
    chk("tmo_fv", 32'(frame_valid), 1);
    chk("tmo_cnt", 32'(dct_count), 3);
    chk("tmo_buf", 32'(dct_buffer), 32'h3F);
    frame_ready = 1;
    cyc();
    chk("tmo_clr_fv", 32'(frame_valid), 0);

    // Test end with an atom accepted in the same cycle
    do_reset();
    trace_en = 1; frame_ready = 0;
    for (int k = 0; k < 5; k++) push_atom(2'($urandom_range(0, 3)));
    atom_valid = 1; atom = 2'd2; test_ending = 1;
    cyc();
    chk("end_fv", 32'(frame_valid), 1);
    chk("end_cnt", 32'(dct_count), 6);
    chk("end_slot5", 32'(dct_buffer[11:10]), 2);
    frame_ready = 1;
    cyc();
    chk("end_ended", 32'(test_has_ended), 1);
    chk("end_ready", 32'(atom_ready), 0);
    test_ending = 0;
    for (int c = 0; c < 3; c++) cyc();
    chk("end_sticky", 32'(test_has_ended), 1);
    chk("end_ready2", 32'(atom_ready), 0);
    chk("end_fv2", 32'(frame_valid), 0);
    atom_valid = 0;

    // Reset while a frame is pending
    do_reset();
    trace_en = 1; frame_ready = 0;
    for (int k = 0; k < APF; k++) push_atom(2'(k % 4));
    chk("rmid_fv_before", 32'(frame_valid), 1);
    reset = 1;
    #1;
    chk("rmid_fv", 32'(frame_valid), 0);
    chk("rmid_cnt", 32'(dct_count), 0);
    chk("rmid_buf", 32'(dct_buffer), 0);
    chk("rmid_ended", 32'(test_has_ended), 0);
    cyc();
    reset = 0;
    cyc();
    push_atom(2'd3);
    chk("rmid_slot0_cnt", 32'(dct_count), 1);
    chk("rmid_slot0_buf", 32'(dct_buffer), 3);

`ifdef DCT_LOSSY_MODE_EN
    // Lossy: atoms offered during FLUSH are dropped
    do_reset();
    chk("lossy_drop0", 32'(drop_count), 0);
    trace_en = 1; frame_ready = 0;
    for (int k = 0; k < APF; k++) push_atom(2'(k % 4));
    for (int k = 0; k < 4; k++) push_atom(2'd1);
    chk("lossy_drop4", 32'(drop_count), 4);
    chk("lossy_buf", 32'(dct_buffer), 32'h24E4E4E4);
    chk("lossy_cnt", 32'(dct_count), 15);
    frame_ready = 1;
    cyc();
`endif

    // Randomized phase
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      vprob = ((c / 500) % 2 == 0) ? 3 : 60;
      trace_en    = ($urandom_range(0, 19) != 0);
      atom_valid  = ($urandom_range(0, vprob) == 0) ? 1'b0 : ($urandom_range(0, vprob) < 3);
      if (vprob == 3) atom_valid = ($urandom_range(0, 3) != 0);
      atom        = 2'($urandom_range(0, 3));
      frame_ready = ($urandom_range(0, 2) != 0);
      test_ending = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 249) == 0) begin
        reset = 1;
        cyc();
        reset = 0;
      end else begin
        cyc();
      end
    end
    trace_en = 0; atom_valid = 0; test_ending = 0;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
